// File: rtl/sram_access_arbiter.sv
// Single-port SRAM arbiter: VGA display fetches have fixed priority over CPU traffic.
// Optional VGA_BURST_LIMIT_EN: CPU wins after MAX_VGA_BURST VGA grants made while it waited.
module sram_access_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MAX_VGA_BURST = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_done,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [3:0]        cpu_sel,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              sram_busy,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_read,
    output logic              sram_write,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic [3:0]        sram_sel
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VGA  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;

    logic [1:0] state;
    logic [1:0] owner;
    logic       we_q;
    logic       cpu_forced;
    logic       grant_vga;
    logic       grant_cpu;

`ifdef VGA_BURST_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_VGA_BURST + 2);
    logic [CNT_W-1:0] burst_cnt;

    always_comb begin
        cpu_forced = cpu_req && (32'(burst_cnt) >= MAX_VGA_BURST);
    end

    // Counts VGA grants that kept a waiting CPU out; any CPU grant clears it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            burst_cnt <= '0;
        end else if (grant_cpu) begin
            burst_cnt <= '0;
        end else if (grant_vga && cpu_req && (32'(burst_cnt) < MAX_VGA_BURST)) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end
`else
    always_comb begin
        cpu_forced = 1'b0;
    end
`endif

    always_comb begin
        grant_vga = (state == S_IDLE) && vga_req && !cpu_forced;
        grant_cpu = (state == S_IDLE) && cpu_req && !grant_vga;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            owner      <= OWN_NONE;
            we_q       <= 1'b0;
            vga_done   <= 1'b0;
            vga_rdata  <= '0;
            cpu_done   <= 1'b0;
            cpu_rdata  <= '0;
            sram_read  <= 1'b0;
            sram_write <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_sel   <= '0;
        end else begin
            sram_read  <= 1'b0;
            sram_write <= 1'b0;
            vga_done   <= 1'b0;
            cpu_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Strobe is registered here so it is high for exactly the ISSUE cycle.
                    if (grant_vga) begin
                        owner     <= OWN_VGA;
                        we_q      <= 1'b0;
                        sram_addr <= vga_addr;
                        sram_sel  <= 4'hF;
                        sram_read <= 1'b1;
                        state     <= S_ISSUE;
                    end else if (grant_cpu) begin
                        owner      <= OWN_CPU;
                        we_q       <= cpu_we;
                        sram_addr  <= cpu_addr;
                        sram_wdata <= cpu_wdata;
                        sram_sel   <= cpu_sel;
                        sram_read  <= !cpu_we;
                        sram_write <= cpu_we;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!sram_busy) begin
                        if (owner == OWN_VGA) begin
                            vga_rdata <= sram_rdata;
                            vga_done  <= 1'b1;
                        end else begin
                            cpu_done <= 1'b1;
                            if (!we_q) begin
                                cpu_rdata <= sram_rdata;
                            end
                        end
                        state <= S_DONE;
                    end
                end
                default: begin
                    owner <= OWN_NONE;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed + randomized bench for sram_access_arbiter with an SRAM model and a
// transaction-level reference (arbitration rule, memory array, latency arithmetic).
module tb_sram_access_arbiter;

    localparam int unsigned MAX_BURST = 4;

    logic        tb_clk = 1'b0;
    logic        nrst;
    logic        vga_req;
    logic [31:0] vga_addr;
    logic        vga_done;
    logic [31:0] vga_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_sel;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        sram_busy;
    logic [31:0] sram_rdata;
    logic        sram_read;
    logic        sram_write;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_sel;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic [31:0] smem    [0:255];
    logic [31:0] ref_mem [0:255];
    int unsigned sram_lat = 0;
    int unsigned busy_cnt = 0;
    int unsigned ref_burst = 0;
    logic [31:0] exp_vga = '0;
    logic [31:0] exp_cpu = '0;

    sram_access_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_VGA_BURST(MAX_BURST)
    ) dut (
        .clk(tb_clk),
        .nrst(nrst),
        .vga_req(vga_req),
        .vga_addr(vga_addr),
        .vga_done(vga_done),
        .vga_rdata(vga_rdata),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_sel(cpu_sel),
        .cpu_done(cpu_done),
        .cpu_rdata(cpu_rdata),
        .sram_busy(sram_busy),
        .sram_rdata(sram_rdata),
        .sram_read(sram_read),
        .sram_write(sram_write),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_sel(sram_sel)
    );

    always #20 tb_clk = ~tb_clk;

    // SRAM: acts on the strobe, then holds busy for sram_lat full WAIT cycles.
    always @(negedge tb_clk or negedge nrst) begin
        if (!nrst) begin
            sram_busy = 1'b0;
            busy_cnt  = 0;
        end else if (sram_read || sram_write) begin
            if (sram_write) begin
                for (int b = 0; b < 4; b++)
                    if (sram_sel[b]) smem[sram_addr[7:0]][8*b +: 8] = sram_wdata[8*b +: 8];
            end else begin
                sram_rdata = smem[sram_addr[7:0]];
            end
            busy_cnt  = sram_lat;
            sram_busy = (sram_lat != 0);
        end else begin
            sram_busy = (busy_cnt != 0);
            if (busy_cnt != 0) busy_cnt--;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    function automatic bit ref_pick_vga();
        bit v;
        v = vga_req;
`ifdef VGA_BURST_LIMIT_EN
        if (cpu_req && ref_burst >= MAX_BURST) v = 1'b0;
`endif
        if (v && cpu_req) ref_burst++;
        else if (!v) ref_burst = 0;
        return v;
    endfunction

    // Called in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
    task automatic transact(input int unsigned lat, input bit drop_vga, output bit cpu_served);
        bit          pv;
        bit          ew;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  es;
        int unsigned n;
        bit          seen;
        pv = ref_pick_vga();
        if (pv) begin
            ea = vga_addr; es = 4'hF; ew = 1'b0; ed = ref_mem[vga_addr[7:0]];
        end else begin
            ea = cpu_addr; es = cpu_sel; ew = cpu_we; ed = ref_mem[cpu_addr[7:0]];
            if (ew)
                for (int b = 0; b < 4; b++)
                    if (cpu_sel[b]) ref_mem[cpu_addr[7:0]][8*b +: 8] = cpu_wdata[8*b +: 8];
        end
        sram_lat = lat;
        tick();
        chk("issue_strobes", 64'({sram_read, sram_write}), ew ? 64'd1 : 64'd2);
        chk("issue_addr", 64'(sram_addr), 64'(ea));
        chk("issue_sel", 64'(sram_sel), 64'(es));
        if (ew) chk("issue_wdata", 64'(sram_wdata), 64'(cpu_wdata));
        tick();
        chk("wait_strobes", 64'({sram_read, sram_write}), 64'd0);
        if (drop_vga) vga_req = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 64) begin
            tick();
            n++;
            seen = vga_done || cpu_done;
        end
        chk("done_latency", 64'(n), 64'(lat + 1));
        chk("done_owner", 64'({vga_done, cpu_done}), pv ? 64'd2 : 64'd1);
        cpu_served = cpu_done;
        if (pv) exp_vga = ed;
        else if (!ew) exp_cpu = ed;
        chk("vga_rdata", 64'(vga_rdata), 64'(exp_vga));
        chk("cpu_rdata", 64'(cpu_rdata), 64'(exp_cpu));
        tick();
        chk("done_pulse", 64'({vga_done, cpu_done}), 64'd0);
    endtask

    initial begin
        bit          got_cpu;
        int unsigned cpu_grants;
        int unsigned first_cpu;
        int unsigned dcount;
        logic [31:0] v;

        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            smem[i] = v;
            ref_mem[i] = v;
        end
        sram_rdata = '0;
        nrst = 1'b1;
        vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_sel = '0;
        #5 nrst = 1'b0;
        tick(); tick();
        chk("rst_ctrl", 64'({vga_done, cpu_done, sram_read, sram_write, sram_sel}), 64'd0);
        chk("rst_addr_wdata", {sram_addr, sram_wdata}, 64'd0);
        chk("rst_rdata", {vga_rdata, cpu_rdata}, 64'd0);
        @(negedge tb_clk) nrst = 1'b1;
        tick();

        // VGA read of all-ones word, zero SRAM latency
        smem[5] = 32'hFFFF_FFFF; ref_mem[5] = 32'hFFFF_FFFF;
        vga_req = 1'b1; vga_addr = 32'd5;
        transact(0, 1'b0, got_cpu);
        vga_req = 1'b0;

        // CPU read so cpu_rdata is non-zero before the write below
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd9; cpu_sel = 4'hF;
        transact(1, 1'b0, got_cpu);
        cpu_req = 1'b0;

        // CPU partial write with busy held 3 cycles
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd2; cpu_wdata = 32'h6AAA_5556; cpu_sel = 4'b0011;
        transact(3, 1'b0, got_cpu);
        cpu_req = 1'b0;
        chk("mem_after_write", 64'(smem[2]), 64'(ref_mem[2]));

        // Simultaneous requests: VGA first, then CPU
        vga_req = 1'b1; vga_addr = 32'hA500_0011;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0002; cpu_sel = 4'hF;
        transact(2, 1'b0, got_cpu);
        chk("tie_first_vga", 64'(got_cpu), 64'd0);
        vga_req = 1'b0;
        transact(0, 1'b0, got_cpu);
        chk("tie_then_cpu", 64'(got_cpu), 64'd1);
        cpu_req = 1'b0;

        // Randomized mix; a requester only drops req after its own done
        for (int i = 0; i < 24; i++) begin
            if (!vga_req && $urandom_range(0, 1) == 1) begin
                vga_req = 1'b1; vga_addr = $urandom;
            end
            if (!cpu_req && $urandom_range(0, 1) == 1) begin
                cpu_req = 1'b1; cpu_we = $urandom_range(0, 1) == 1;
                cpu_addr = $urandom; cpu_wdata = $urandom; cpu_sel = 4'($urandom_range(0, 15));
            end
            if (!vga_req && !cpu_req) begin
                vga_req = 1'b1; vga_addr = $urandom;
            end
            transact($urandom_range(0, 3), 1'b0, got_cpu);
            if (got_cpu) cpu_req = 1'b0;
            else vga_req = 1'b0;
        end
        vga_req = 1'b0;
        cpu_req = 1'b0;
        ref_burst = 0;
        tick();

        // Continuous VGA traffic with a waiting CPU
        cpu_grants = 0;
        first_cpu = 99;
        vga_req = 1'b1; vga_addr = $urandom;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = $urandom; cpu_sel = 4'hF;
        for (int i = 0; i < 10; i++) begin
            transact($urandom_range(0, 1), 1'b0, got_cpu);
            if (got_cpu) begin
                cpu_grants++;
                if (first_cpu == 99) first_cpu = i;
                cpu_req = 1'b0;
            end else begin
                vga_addr = $urandom;
            end
        end
`ifdef VGA_BURST_LIMIT_EN
        chk("burst_cpu_grants", 64'(cpu_grants), 64'd1);
        chk("burst_cpu_slot", 64'(first_cpu), 64'(MAX_BURST));
`else
        chk("starve_cpu_grants", 64'(cpu_grants), 64'd0);
        chk("starve_cpu_slot", 64'(first_cpu), 64'd99);
`endif
        vga_req = 1'b0;
        cpu_req = 1'b0;
        ref_burst = 0;
        tick();

        // VGA req dropped mid-WAIT: its done still pulses, then CPU is served
        vga_req = 1'b1; vga_addr = 32'd77;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd78; cpu_sel = 4'hF;
        transact(2, 1'b1, got_cpu);
        chk("drop_vga_done", 64'(got_cpu), 64'd0);
        transact(1, 1'b0, got_cpu);
        chk("drop_then_cpu", 64'(got_cpu), 64'd1);
        cpu_req = 1'b0;

        // Reset asserted mid-WAIT
        vga_req = 1'b1; vga_addr = 32'd40; sram_lat = 6;
        tick(); tick(); tick();
        #5 nrst = 1'b0;
        #1;
        chk("midrst_ctrl", 64'({vga_done, cpu_done, sram_read, sram_write, sram_sel}), 64'd0);
        chk("midrst_addr_wdata", {sram_addr, sram_wdata}, 64'd0);
        chk("midrst_rdata", {vga_rdata, cpu_rdata}, 64'd0);
        vga_req = 1'b0;
        exp_vga = '0; exp_cpu = '0; ref_burst = 0;
        @(negedge tb_clk) nrst = 1'b1;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            dcount += 32'(vga_done) + 32'(cpu_done);
        end
        chk("no_done_after_rst", 64'(dcount), 64'd0);

        // Normal service after reset
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd2; cpu_sel = 4'hF;
        transact(0, 1'b0, got_cpu);
        cpu_req = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
